// File: rtl/vga_map_pkg.sv
// Shared constants for the world-map ROM port: widths, map codes and
// the encoding of which requester owns a ROM slot.
package vga_map_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 2;

    localparam logic [1:0] EMPTY       = 2'd0;
    localparam logic [1:0] BLACK_LINE  = 2'd1;
    localparam logic [1:0] OBSTRUCTION = 2'd2;
    localparam logic [1:0] RESERVED    = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/vga_map_addr_cache.sv
// One-entry address cache for the VGA pixel path: tag/valid compare in
// stage 0, cached map code refilled from the ROM in stage 1.
module vga_map_addr_cache #(
    parameter int ADDR_W = vga_map_pkg::ADDR_W,
    parameter int DATA_W = vga_map_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              tag_wr,
    input  logic              inv,
    input  logic              fill,
    input  logic              use_cache,
    input  logic [DATA_W-1:0] mem_data,
    output logic              hit,
    output logic [DATA_W-1:0] data_out
);
    import vga_map_pkg::*;

    logic [ADDR_W-1:0] tag_q;
    logic              tag_vld_q;
    logic [DATA_W-1:0] cache_data_q;

    assign hit      = tag_vld_q && (lookup_addr == tag_q);
    assign data_out = use_cache ? cache_data_q : mem_data;

    // Invalidation wins over a same-cycle tag write so a map switch never
    // leaves a stale entry marked valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q        <= '0;
            tag_vld_q    <= 1'b0;
            cache_data_q <= '0;
        end else begin
            if (inv)
                tag_vld_q <= 1'b0;
            else if (tag_wr)
                tag_vld_q <= 1'b1;
            if (tag_wr)
                tag_q <= lookup_addr;
            if (fill)
                cache_data_q <= mem_data;
        end
    end

endmodule

// File: rtl/vga_map_port_arbiter.sv
// Shares the single-port world-map ROM between the fixed-latency VGA pixel
// path (absolute priority, cached repeats) and the CPU sensor read port.
module vga_map_port_arbiter #(
    parameter int ADDR_W       = vga_map_pkg::ADDR_W,
    parameter int DATA_W       = vga_map_pkg::DATA_W,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_data_valid,
    input  logic              cache_inv,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_starved,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
);
    import vga_map_pkg::*;

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == STARVE_MAX) ? v : v + 1'b1;
    endfunction

    logic              cache_hit;
    logic              vga_miss_p0;
    logic              cpu_grant_p0;
    logic              cpu_wait_p0;
    owner_e            owner_p0;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              cpu_inflight;

    logic              vld_p1;
    logic              hit_p1;
    owner_e            owner_p1;
    logic              fill_p1;
    logic              cpu_rd_p1;
    logic [DATA_W-1:0] vga_rd_p1;

    logic              vld_p2;
    logic              ack_p2;
    logic [DATA_W-1:0] vga_data_p2;
    logic [DATA_W-1:0] cpu_data_p2;

    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_cnt_nxt;
    logic              starved;

    assign fill_p1   = (owner_p1 == OWN_VGA);
    assign cpu_rd_p1 = (owner_p1 == OWN_CPU);

    vga_map_addr_cache #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_cache (
        .clk        (clk),
        .reset      (reset),
        .lookup_addr(vga_addr),
        .tag_wr     (vga_miss_p0),
        .inv        (cache_inv),
        .fill       (fill_p1),
        .use_cache  (hit_p1),
        .mem_data   (mem_data),
        .hit        (cache_hit),
        .data_out   (vga_rd_p1)
    );

    // Stage 0: arbitration; an idle slot keeps the last address on the ROM.
    always_comb begin
        vga_miss_p0  = 1'b0;
        cpu_grant_p0 = 1'b0;
        cpu_wait_p0  = 1'b0;
        owner_p0     = OWN_NONE;
        mem_addr     = mem_addr_q;
        if (!reset) begin
            vga_miss_p0  = vga_valid && !cache_hit;
            cpu_grant_p0 = !vga_miss_p0 && cpu_req && !cpu_inflight;
            cpu_wait_p0  = cpu_req && !cpu_inflight && !cpu_grant_p0;
        end
        if (vga_miss_p0) begin
            owner_p0 = OWN_VGA;
            mem_addr = vga_addr;
        end else if (cpu_grant_p0) begin
            owner_p0 = OWN_CPU;
            mem_addr = cpu_addr;
        end
    end

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (cpu_grant_p0)
            starve_cnt_nxt = '0;
        else if (cpu_wait_p0)
            starve_cnt_nxt = sat_inc(starve_cnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q   <= '0;
            cpu_inflight <= 1'b0;
            vld_p1       <= 1'b0;
            hit_p1       <= 1'b0;
            owner_p1     <= OWN_NONE;
            vld_p2       <= 1'b0;
            ack_p2       <= 1'b0;
            vga_data_p2  <= '0;
            cpu_data_p2  <= '0;
            starve_cnt   <= '0;
            starved      <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr;
            // The ack cycle still counts as in flight; a new grant follows it.
            if (cpu_grant_p0)
                cpu_inflight <= 1'b1;
            else if (ack_p2)
                cpu_inflight <= 1'b0;

            // Stage 1: ROM data for the stage-0 owner is on mem_data.
            vld_p1   <= vga_valid;
            hit_p1   <= vga_valid && cache_hit;
            owner_p1 <= owner_p0;

            // Stage 2: registered outputs, data held between valid cycles.
            vld_p2 <= vld_p1;
            if (vld_p1)
                vga_data_p2 <= vga_rd_p1;
            ack_p2 <= cpu_rd_p1;
            if (cpu_rd_p1)
                cpu_data_p2 <= mem_data;

            starve_cnt <= starve_cnt_nxt;
            if (starve_cnt_nxt == STARVE_MAX)
                starved <= 1'b1;
        end
    end

    assign vga_data       = vga_data_p2;
    assign vga_data_valid = vld_p2;
    assign cpu_ack        = ack_p2;
    assign cpu_data       = cpu_data_p2;
    assign cpu_starved    = starved;

endmodule

// File: tb/tb_vga_map_port_arbiter.sv
// Bench for vga_map_port_arbiter: a map-level model (map[addr], priority and
// latency rules) checked every cycle, plus directed literal expectations.
module tb_vga_map_port_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 2;
    localparam int LIM_A = 1024;
    localparam int LIM_B = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_valid = 1'b0;
    logic          cache_inv = 1'b0;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;

    logic [DW-1:0] vga_data_a, cpu_data_a, mem_data_a;
    logic          vdv_a, ack_a, starved_a;
    logic [AW-1:0] mem_addr_a;
    logic [DW-1:0] vga_data_b, cpu_data_b, mem_data_b;
    logic          vdv_b, ack_b, starved_b;
    logic [AW-1:0] mem_addr_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_map_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM_A)) dut_a (
        .clk(clk), .reset(reset), .vga_addr(vga_addr), .vga_valid(vga_valid),
        .vga_data(vga_data_a), .vga_data_valid(vdv_a), .cache_inv(cache_inv),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(ack_a), .cpu_data(cpu_data_a),
        .cpu_starved(starved_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a)
    );

    vga_map_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM_B)) dut_b (
        .clk(clk), .reset(reset), .vga_addr(vga_addr), .vga_valid(vga_valid),
        .vga_data(vga_data_b), .vga_data_valid(vdv_b), .cache_inv(cache_inv),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(ack_b), .cpu_data(cpu_data_b),
        .cpu_starved(starved_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b)
    );

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return a[1:0];
    endfunction

    // One-cycle synchronous ROM per DUT.
    always @(posedge clk) begin
        mem_data_a <= rom(mem_addr_a);
        mem_data_b <= rom(mem_addr_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // CPU requester: drop the request on the ack cycle.
    always @(posedge clk) begin
        #2;
        if (ack_a) cpu_req = 1'b0;
    end

    // Map-level model: every VGA pixel sees map[addr] two cycles later, every
    // grant returns map[cpu_addr] two cycles later; a ROM slot goes to a VGA
    // miss first, otherwise to an idle CPU request.
    bit            armed = 1'b0;
    logic          m_tag_v;
    logic [AW-1:0] m_tag, m_hold;
    int            m_busy, m_wait, m_vga_reads;
    logic          m_vdv, m_ack, n_vdv, n_ack, m_st_a, m_st_b;
    logic [DW-1:0] m_vd, m_cd, n_vd, n_cd;

    always @(negedge clk) begin
        logic          hit, miss, grant, waiting;
        logic [AW-1:0] ea;
        if (armed) begin
            check("vga_data_valid", 32'(vdv_a), 32'(m_vdv));
            check("vga_data", 32'(vga_data_a), 32'(m_vd));
            check("cpu_ack", 32'(ack_a), 32'(m_ack));
            check("cpu_data", 32'(cpu_data_a), 32'(m_cd));
            check("cpu_starved_a", 32'(starved_a), 32'(m_st_a));
            check("vga_data_b", 32'(vga_data_b), 32'(m_vd));
            check("cpu_ack_b", 32'(ack_b), 32'(m_ack));
            check("cpu_starved_b", 32'(starved_b), 32'(m_st_b));
        end
        if (reset) begin
            if (armed) check("mem_addr_in_reset", 32'(mem_addr_a), 32'(m_hold));
            m_hold = '0; m_tag = '0; m_tag_v = 1'b0;
            m_busy = 0; m_wait = 0;
            m_vdv = 1'b0; m_ack = 1'b0; n_vdv = 1'b0; n_ack = 1'b0;
            m_vd = '0; m_cd = '0; n_vd = '0; n_cd = '0;
            m_st_a = 1'b0; m_st_b = 1'b0;
            if (!armed) m_vga_reads = 0;
            armed = 1'b1;
        end else if (armed) begin
            hit     = m_tag_v && (vga_addr == m_tag);
            miss    = vga_valid && !hit;
            grant   = !miss && cpu_req && (m_busy == 0);
            waiting = cpu_req && (m_busy == 0) && !grant;
            ea = miss ? vga_addr : (grant ? cpu_addr : m_hold);
            check("mem_addr", 32'(mem_addr_a), 32'(ea));
            check("mem_addr_b", 32'(mem_addr_b), 32'(ea));
            m_hold = ea;
            if (miss) begin
                m_tag = vga_addr; m_tag_v = 1'b1; m_vga_reads++;
            end
            if (cache_inv) m_tag_v = 1'b0;
            m_vdv = n_vdv; if (n_vdv) m_vd = n_vd;
            m_ack = n_ack; if (n_ack) m_cd = n_cd;
            n_vdv = vga_valid; n_vd = rom(vga_addr);
            n_ack = grant;     n_cd = rom(cpu_addr);
            if (m_busy > 0) m_busy--;
            if (grant) m_busy = 2;
            if (grant) m_wait = 0;
            else if (waiting) m_wait++;
            if (m_wait >= LIM_A) m_st_a = 1'b1;
            if (m_wait >= LIM_B) m_st_b = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic drive(input logic vv, input logic [AW-1:0] va, input logic inv);
        vga_valid = vv; vga_addr = va; cache_inv = inv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        reset = 1'b1;
        repeat (3) tick();
        check("reset vga_data_valid", 32'(vdv_a), 32'd0);
        check("reset vga_data", 32'(vga_data_a), 32'd0);
        check("reset cpu_ack", 32'(ack_a), 32'd0);
        check("reset cpu_data", 32'(cpu_data_a), 32'd0);
        check("reset cpu_starved", 32'(starved_a), 32'd0);
        check("reset mem_addr", 32'(mem_addr_a), 32'd0);
        reset = 1'b0;

        // Reset arriving one cycle after a CPU grant drops the request.
        cpu_req = 1'b1; cpu_addr = 14'h0405;
        mid(); check("grant before reset", 32'(mem_addr_a), 32'h0405);
        tick();
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        mid(); check("no ack after reset", 32'(ack_a), 32'd0);
        check("cpu_data after reset", 32'(cpu_data_a), 32'd0);
        tick();

        // 6-pixel run at 0x0203, then 0x0204; CPU takes the first hit slot.
        base = m_vga_reads;
        drive(1'b1, 14'h0203, 1'b0);
        cpu_req = 1'b1; cpu_addr = 14'h1FFF;
        mid(); check("first vga after reset misses", 32'(mem_addr_a), 32'h0203);
        tick();
        mid(); check("cpu in hit slot", 32'(mem_addr_a), 32'h1FFF);
        tick();
        mid(); check("run first pixel valid", 32'(vdv_a), 32'd1);
        check("run first pixel data", 32'(vga_data_a), 32'd3);
        tick();
        mid(); check("cpu ack in run", 32'(ack_a), 32'd1);
        check("cpu data in run", 32'(cpu_data_a), 32'd3);
        tick();
        tick();
        tick();
        drive(1'b1, 14'h0204, 1'b0);
        mid(); check("run end miss", 32'(mem_addr_a), 32'h0204);
        tick();
        drive(1'b0, 14'h0204, 1'b0);
        mid(); check("run last repeat data", 32'(vga_data_a), 32'd3);
        tick();
        mid(); check("run new addr data", 32'(vga_data_a), 32'd0);
        check("run new addr valid", 32'(vdv_a), 32'd1);
        tick();
        mid(); check("valid drops", 32'(vdv_a), 32'd0);
        check("vga rom reads in run", 32'(m_vga_reads - base), 32'd2);
        tick();

        // Ten consecutive misses lock the CPU out; it gets cycle 11.
        cpu_req = 1'b1; cpu_addr = 14'h0776;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'(14'h0300 + i), 1'b0);
            mid();
            tick();
        end
        drive(1'b0, 14'h0000, 1'b0);
        mid(); check("cpu granted after burst", 32'(mem_addr_a), 32'h0776);
        tick();
        tick();
        mid(); check("burst cpu ack", 32'(ack_a), 32'd1);
        check("burst cpu data", 32'(cpu_data_a), 32'd2);
        check("no starve at 1024", 32'(starved_a), 32'd0);
        check("starve at 8 after 10 waits", 32'(starved_b), 32'd1);
        tick();

        // Starvation threshold and stickiness (limit 8 instance).
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("starve cleared by reset", 32'(starved_b), 32'd0);
        cpu_req = 1'b1; cpu_addr = 14'h0999;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, AW'(14'h0400 + i), 1'b0);
            mid();
            if (i == 7) check("starve not yet after 7 waits", 32'(starved_b), 32'd0);
            if (i == 8) check("starve after 8 waits", 32'(starved_b), 32'd1);
            tick();
        end
        drive(1'b0, 14'h0000, 1'b0);
        mid(); check("starved cpu granted", 32'(mem_addr_a), 32'h0999);
        tick();
        tick();
        mid(); check("starved cpu ack", 32'(ack_b), 32'd1);
        check("starve sticky after grant", 32'(starved_b), 32'd1);
        tick();

        // Invalidate during a repeated address.
        base = m_vga_reads;
        drive(1'b1, 14'h0100, 1'b0);
        mid();
        tick();
        cpu_req = 1'b1; cpu_addr = 14'h0AAA;
        mid(); check("hit slot before inv", 32'(mem_addr_a), 32'h0AAA);
        tick();
        drive(1'b1, 14'h0100, 1'b1);
        mid(); check("same-cycle inv still hit", 32'(mem_addr_a), 32'h0AAA);
        tick();
        drive(1'b1, 14'h0100, 1'b0);
        mid(); check("miss after inv", 32'(mem_addr_a), 32'h0100);
        tick();
        mid(); check("hit after refill", 32'(mem_addr_a), 32'h0100);
        check("vga rom reads around inv", 32'(m_vga_reads - base), 32'd2);
        tick();

        // Invalidate beats a simultaneous tag write.
        drive(1'b1, 14'h0155, 1'b1);
        mid();
        tick();
        drive(1'b1, 14'h0155, 1'b0);
        cpu_req = 1'b1; cpu_addr = 14'h0BBB;
        mid(); check("inv beats tag write", 32'(mem_addr_a), 32'h0155);
        tick();
        mid(); check("cpu after refill", 32'(mem_addr_a), 32'h0BBB);
        tick();
        drive(1'b0, 14'h0000, 1'b0);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_map_port_arbiter.md
Name: vga_map_port_arbiter

Overview:
- Shares the single-port world-map block ROM (128x128 entries, 2-bit map code, 1-cycle synchronous read) between two requesters:
  - the VGA pixel path, which carries the world address produced by the screen-to-world scaler;
  - the bot/CPU sensor read port.
- The VGA path is hard real-time and always receives its data with a fixed 2-cycle latency.
- Because 6x6 scaling repeats each world address for runs of consecutive pixels, a one-entry address cache absorbs repeats. The freed ROM slots are given to the CPU port.

Parameters:
- ADDR_W, 14, ROM address width ({world_row, world_column}).
- DATA_W, 2, map code width.
- STARVE_LIMIT, 1024, CPU wait cycles before the starvation flag sets.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vga_addr  in  ADDR_W  world address from the scaler.
- vga_valid  in  1  video_on AND NOT out_of_map; the pixel needs map data this cycle.
- vga_data  out  DATA_W  map code for the pixel presented 2 cycles earlier.
- vga_data_valid  out  1  vga_valid delayed by 2 cycles.
- cache_inv  in  1  invalidates the cached address (asserted on map switch).
- cpu_req  in  1  level request; held until cpu_ack.
- cpu_addr  in  ADDR_W  CPU read address; stable while cpu_req is high.
- cpu_ack  out  1  one-cycle pulse; cpu_data is valid in the same cycle.
- cpu_data  out  DATA_W  read result, held until the next ack.
- cpu_starved  out  1  sticky; set when a CPU request waits STARVE_LIMIT cycles.
- mem_addr  out  ADDR_W  ROM address.
- mem_data  in  DATA_W  ROM data for the address issued in the previous cycle.

Behaviour:
- Reset (synchronous, all registers):
  - vga_data, cpu_data, mem_addr = 0.
  - vga_data_valid, cpu_ack, cpu_starved = 0.
  - Cache tag invalid; CPU in-flight cleared.
  - Requests in flight when reset is asserted are dropped: no ack is issued, and cpu_req must be re-presented after reset.
- Stage 0 (cycle t), arbitration:
  - VGA miss = vga_valid AND (tag invalid OR vga_addr != tag).
  - If VGA miss: mem_addr = vga_addr, owner = VGA; tag <= vga_addr, tag valid <= 1.
  - Else if cpu_req AND NOT cpu_inflight: mem_addr = cpu_addr, owner = CPU; cpu_inflight <= 1.
  - Else: mem_addr holds its previous value (ROM read ignored).
  - VGA has absolute priority. A VGA hit never uses the ROM.
- Stage 1 (t+1):
  - Registered {vga_valid, vga_hit, cpu_owner} are used.
  - VGA data = hit ? cache_data : mem_data.
  - On a VGA miss, cache_data <= mem_data.
  - A hit issued at t+1 reads the cache_data written at the end of t+1. This is correct for back-to-back miss then hit on the same address.
- Stage 2 (t+2):
  - vga_data / vga_data_valid are registered outputs.
  - When vga_data_valid = 0, vga_data holds its last value.
  - For a CPU grant at t: cpu_data <= mem_data at the end of t+1, so cpu_ack = 1 and cpu_data are visible at t+2; cpu_inflight is cleared in the same cycle.
- CPU handshake:
  - A new grant is not possible until the cycle after ack.
  - If cpu_req is still high in the cycle after ack, it is treated as a new request.
- cache_inv:
  - Clears tag valid at the end of the cycle.
  - A VGA request in the same cycle as cache_inv is evaluated against the old tag. The invalidation applies from the next cycle.
  - cache_inv has priority over a simultaneous tag write, so the tag ends invalid.
- Starvation counter:
  - Counts cycles with cpu_req AND NOT cpu_inflight AND NOT granted.
  - Clears on grant.
  - Saturates at STARVE_LIMIT; at STARVE_LIMIT, cpu_starved <= 1 (sticky until reset).
- Throughput: every VGA cycle gets its data; no back-pressure exists on the VGA port.

Decomposition:
- Shared package (vga_map_pkg):
  - ADDR_W and DATA_W;
  - map code constants (EMPTY, BLACK_LINE, OBSTRUCTION, RESERVED);
  - owner encoding (OWN_NONE, OWN_VGA, OWN_CPU).
- One natural sub-module: vga_map_addr_cache. It holds the tag, valid bit and cache_data, and exposes a hit output and a data mux.
- Arbitration and pipeline registers stay in the top-level module.

Test Plan:
- Reset mid-grant: grant CPU at addr 0x0405, assert reset at t+1 -> no cpu_ack; all outputs 0; first VGA request after reset is a miss.
- VGA run with ROM model (data = addr[1:0]): vga_addr = 0x0203 for 6 cycles, then 0x0204 -> exactly 2 ROM reads; vga_data = 3 x6 then 0 with 2-cycle latency.
- CPU in hit slots: cpu_req with addr 0x1FFF during the above run -> granted in the 2nd cycle of the run (first hit); cpu_ack 2 cycles later with data 3; no VGA glitch.
- Simultaneous miss and CPU request: vga_valid with a new address each cycle for 10 cycles plus cpu_req -> CPU waits all 10 cycles and is granted in cycle 11; cpu_starved stays 0 (STARVE_LIMIT=1024).
- Starvation: STARVE_LIMIT=8, VGA misses every cycle for 12 cycles -> cpu_starved rises after 8 waiting cycles and stays high after the grant.
- Invalidate: cache_inv while vga_addr is repeated at 0x0100 -> the next cycle is a miss with an extra ROM read; same-cycle request is still a hit.
